// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the MIPS-subset datapath.
// One shared memory port, the ALU, the PC and the register file are sequenced
// over 3-5 cycles per instruction. Memory accesses in FETCH, MEMRD and MEMWR
// stall on mem_ready. Retired instructions are counted, and an all-zero or
// illegal instruction parks the FSM in HALT until reset.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset (state FETCH, retired 0)
//   ir[31:0]       instruction register, valid from DECODE onward
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero (beq)
//   i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   ir_write       load IR from memory data
//   reg_dst        register file destination: 0 = rt, 1 = rd
//   mem_to_reg     writeback source: 0 = ALUOut, 1 = MDR
//   reg_write      register file write enable
//   alu_src_a      0 = PC, 1 = A
//   alu_src_b[1:0] 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op[1:0]    00 = add, 01 = sub, 10 = use funct
//   pc_source[1:0] 00 = ALU result, 01 = ALUOut, 10 = jump target
//   halted         FSM is in HALT
//   state[3:0]     current state encoding
//   retired[31:0]  count of completed instructions (wraps)
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        halted,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTEXE   = 4'd6,
    RTWB    = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEXE = 4'd10,
    ADDIWB  = 4'd11,
    HALT    = 4'd12
  } state_t;

  // Registered Moore control word. 'fetch' marks FETCH so the two
  // mem_ready-gated strobes can be formed outside the register.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  state_t cur;
  state_t nxt;
  ctrl_t  ctl;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      RTEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      RTWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      ADDIEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB: c.reg_write = 1'b1;
      HALT:   c.halted    = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (ir == '0) begin
          nxt = HALT;
        end else begin
          case (ir[31:26])
            6'h00:        nxt = RTEXE;
            6'h23, 6'h2B: nxt = MEMADR;
            6'h04:        nxt = BRANCH;
            6'h02:        nxt = JUMP;
            6'h08:        nxt = ADDIEXE;
            default:      nxt = HALT;
          endcase
        end
      end
      MEMADR:  nxt = (ir[31:26] == 6'h23) ? MEMRD : MEMWR;
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWB:   nxt = FETCH;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      RTEXE:   nxt = RTWB;
      RTWB:    nxt = FETCH;
      BRANCH:  nxt = FETCH;
      JUMP:    nxt = FETCH;
      ADDIEXE: nxt = ADDIWB;
      ADDIWB:  nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = HALT;
    endcase
  end

  // Control word is decoded from the next state so it lines up with the
  // state register; async reset loads the FETCH decode immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= FETCH;
      ctl     <= decode(FETCH);
      retired <= '0;
    end else begin
      cur <= nxt;
      ctl <= decode(nxt);
      if (nxt == FETCH && cur != FETCH) begin
        retired <= retired + 32'd1;
      end
    end
  end

  // FETCH strobes follow mem_ready and are held off while reset is asserted.
  assign ir_write      = ctl.fetch & mem_ready & ~reset;
  assign pc_write      = ctl.pc_write | (ctl.fetch & mem_ready & ~reset);
  assign pc_write_cond = ctl.pc_write_cond;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign reg_dst       = ctl.reg_dst;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_write     = ctl.reg_write;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign pc_source     = ctl.pc_source;
  assign halted        = ctl.halted;
  assign state         = cur;

endmodule
